// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight,
// and hands {instruction, pc} to decode through a valid/ready output register.
module instruction_fetch #(
    parameter int unsigned       XLEN      = 64,
    parameter logic [XLEN-1:0]   RESET_PC  = 64'h0,
    parameter logic [31:0]       NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            drop_q;
    logic [31:0]     hold_instr_q;
    logic [XLEN-1:0] hold_pc_q;

    logic transfer;
    logic slot_free;
    logic misaligned;
    logic hold_load;
    logic outstanding_after;

    assign transfer   = if_valid && id_ready;
    assign slot_free  = !if_valid || id_ready;
    assign misaligned = redirect_pc[1:0] != 2'b00;

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;

    // A live response that finds decode stalled parks in the hold buffer.
    assign hold_load = (state_q == S_WAIT) && imem_resp_valid && !drop_q
                       && !slot_free && !redirect_valid;

    // Whether a memory response is still owed after this cycle, used when a
    // redirect must decide between waiting out a stale response or refetching.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        outstanding_after = 1'b0;
        case (state_q)
            S_REQ:   outstanding_after = imem_req_ready;
            S_WAIT:  outstanding_after = !imem_resp_valid;
            S_FAULT: outstanding_after = drop_q && !imem_resp_valid;
            default: outstanding_after = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            inflight_pc_q  <= RESET_PC;
            drop_q         <= 1'b0;
            fetch_fault    <= 1'b0;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            if_pc          <= '0;
        end else if (redirect_valid) begin
            pc_q           <= redirect_pc;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            drop_q         <= outstanding_after;
            fetch_fault    <= misaligned;
            if (misaligned) begin
                state_q <= S_FAULT;
            end else if (outstanding_after) begin
                state_q <= S_WAIT;
            end else begin
                state_q <= S_REQ;
            end
        end else begin
            if (transfer) begin
                if_valid       <= 1'b0;
                if_instruction <= NOP_INSTR;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        inflight_pc_q <= pc_q;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (slot_free) begin
                            if_valid       <= 1'b1;
                            if_instruction <= imem_resp_data;
                            if_pc          <= inflight_pc_q;
                            pc_q           <= inflight_pc_q + XLEN'(4);
                            state_q        <= S_REQ;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        if_valid       <= 1'b1;
                        if_instruction <= hold_instr_q;
                        if_pc          <= hold_pc_q;
                        pc_q           <= hold_pc_q + XLEN'(4);
                        state_q        <= S_REQ;
                    end
                end
                S_FAULT: begin
                    if (imem_resp_valid && drop_q) begin
                        drop_q <= 1'b0;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // NOTE: the hold buffer is pure data; its occupancy is encoded by S_HOLD,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_instr_q <= imem_resp_data;
            hold_pc_q    <= inflight_pc_q;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (if_valid && !id_ready && !redirect_valid)
        |=> (if_valid && $stable(if_instruction) && $stable(if_pc)));

    a_nop_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !if_valid |-> (if_instruction == NOP_INSTR));

    a_fault_state: assert property (@(posedge clk) disable iff (!rst_n)
        fetch_fault == (state_q == S_FAULT));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory models, an output scoreboard fed
// by the stimulus, and a monitor that pops and compares on every decode transfer.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n, rst_w_n;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [63:0] imem_addr;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready, if_valid, fetch_fault;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;

    logic        req_valid_w, req_ready_w, resp_valid_w, redirect_valid_w;
    logic [63:0] addr_w, redirect_pc_w, if_pc_w;
    logic [31:0] resp_data_w, if_instruction_w;
    logic        id_ready_w, if_valid_w, fetch_fault_w;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] acc_log[$];
    logic [63:0] log_w[$];
    int          n_checks, n_errors, n_xfer;
    int          lat;

    instruction_fetch #(.XLEN(64), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
        .if_instruction(if_instruction), .if_pc(if_pc), .fetch_fault(fetch_fault)
    );

    instruction_fetch #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
        .clk(clk), .rst_n(rst_w_n),
        .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w),
        .imem_addr(addr_w), .imem_resp_valid(resp_valid_w),
        .imem_resp_data(resp_data_w), .redirect_valid(redirect_valid_w),
        .redirect_pc(redirect_pc_w), .id_ready(id_ready_w), .if_valid(if_valid_w),
        .if_instruction(if_instruction_w), .if_pc(if_pc_w), .fetch_fault(fetch_fault_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00500093;
            64'h4:   return 32'h00108113;
            default: return 32'hA000_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n);
        for (int k = 0; k < 200 && n_xfer < n; k++) tick();
        if (n_xfer < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_xfers: got %0d transfers, expected %0d", n_xfer, n);
        end
    endtask

    task automatic wait_acc(input bit which, input int n);
        for (int k = 0; k < 200 && (which ? log_w.size() : acc_log.size()) < n; k++) tick();
        if ((which ? log_w.size() : acc_log.size()) < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_acc%0d: got %0d requests, expected %0d", which,
                     which ? log_w.size() : acc_log.size(), n);
        end
    endtask

    task automatic do_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Memory for dut: variable latency, one outstanding read, abandoned on reset.
    initial begin : mem_a
        int          cnt;
        logic [63:0] maddr;
        cnt = 0;
        maddr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_word(maddr);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    maddr = imem_addr;
                    cnt   = lat;
                    acc_log.push_back(imem_addr);
                end
            end
        end
    end

    // Memory for dut_w: fixed 2-cycle latency.
    initial begin : mem_w
        int          cnt;
        logic [63:0] maddr;
        cnt = 0;
        maddr = '0;
        resp_valid_w = 1'b0;
        resp_data_w  = 32'h0;
        forever begin
            @(negedge clk);
            resp_valid_w = 1'b0;
            if (!rst_w_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        resp_valid_w = 1'b1;
                        resp_data_w  = mem_word(maddr);
                    end
                end
                if (req_valid_w && req_ready_w) begin
                    maddr = addr_w;
                    cnt   = 2;
                    log_w.push_back(addr_w);
                end
            end
        end
    end

    // Scoreboard monitor: every decode transfer must match the oldest expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && id_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got pc 0x%0h, expected no transfer", if_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_pc", if_pc, mon_e.pc);
                    check("out_instr", {32'h0, if_instruction}, {32'h0, mon_e.instr});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n0;
        n_checks = 0; n_errors = 0; n_xfer = 0; lat = 1;
        rst_n = 1'b0; rst_w_n = 1'b0;
        imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        req_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = '0; id_ready_w = 1'b0;

        repeat (3) tick();
        check("rst_if_valid", {63'h0, if_valid}, 64'h0);
        check("rst_if_instr", {32'h0, if_instruction}, {32'h0, NOP});
        check("rst_if_pc", if_pc, 64'h0);
        check("rst_fault", {63'h0, fetch_fault}, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h1);

        // Sequential fetch with decode always ready.
        rst_n = 1'b1;
        tick();
        check("pre_valid_nop", {32'h0, if_instruction}, {32'h0, NOP});
        check("pre_valid_low", {63'h0, if_valid}, 64'h0);
        exp_q.push_back('{64'h0, 32'h00500093});
        exp_q.push_back('{64'h4, 32'h00108113});
        wait_xfers(2);
        id_ready = 1'b0;
        check("addr_seq0", acc_log[0], 64'h0);
        check("addr_seq1", acc_log[1], 64'h4);
        check("addr_seq2", acc_log[2], 64'h8);

        // Decode stall: output holds pc 8, pc 12 parks in hold, no further requests.
        repeat (6) tick();
        check("stall_req_count", 64'(acc_log.size()), 64'd4);
        check("stall_out_pc", if_pc, 64'h8);
        check("stall_out_instr", {32'h0, if_instruction}, 64'hA000_0008);
        do_redirect(64'h0);
        check("flush_valid", {63'h0, if_valid}, 64'h0);
        check("flush_nop", {32'h0, if_instruction}, {32'h0, NOP});
        for (int k = 0; k < 20 && !if_valid; k++) tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("hold_pc", if_pc, 64'h0);
            check("hold_instr", {32'h0, if_instruction}, 64'h0050_0093);
            check("hold_no_req", {63'h0, imem_req_valid}, 64'h0);
        end
        check("hold_req_count", 64'(acc_log.size()), 64'd6);
        exp_q.push_back('{64'h0, 32'h00500093});
        exp_q.push_back('{64'h4, 32'h00108113});
        id_ready = 1'b1;
        tick();
        check("release_pc", if_pc, 64'h4);
        check("release_addr", imem_addr, 64'h8);
        wait_xfers(4);
        id_ready = 1'b0;

        // Redirect to 0x100 in the same cycle the response for pc 8 returns.
        do_redirect(64'h100);
        check("redir_addr", imem_addr, 64'h100);
        check("redir_req", {63'h0, imem_req_valid}, 64'h1);
        check("redir_valid", {63'h0, if_valid}, 64'h0);
        exp_q.push_back('{64'h100, 32'hA000_0100});
        id_ready = 1'b1;
        wait_xfers(5);
        id_ready = 1'b0;
        check("redir_log6", acc_log[6], 64'h8);
        check("redir_log7", acc_log[7], 64'h100);

        // Redirect to 0x200 while waiting on a 3-cycle read.
        lat = 3;
        n0 = acc_log.size();
        wait_acc(1'b0, n0 + 1);
        do_redirect(64'h200);
        check("wait_redir_valid", {63'h0, if_valid}, 64'h0);
        check("wait_redir_noreq", {63'h0, imem_req_valid}, 64'h0);
        exp_q.push_back('{64'h200, 32'hA000_0200});
        id_ready = 1'b1;
        wait_acc(1'b0, n0 + 2);
        check("wait_redir_addr", acc_log[n0 + 1], 64'h200);
        check("wait_redir_still_idle", {63'h0, if_valid}, 64'h0);
        wait_xfers(6);
        id_ready = 1'b0;
        lat = 1;

        // Misaligned redirect faults; an aligned one recovers.
        do_redirect(64'h102);
        check("fault_set", {63'h0, fetch_fault}, 64'h1);
        check("fault_noreq", {63'h0, imem_req_valid}, 64'h0);
        n0 = acc_log.size();
        repeat (6) tick();
        check("fault_sticky", {63'h0, fetch_fault}, 64'h1);
        check("fault_req_count", 64'(acc_log.size()), 64'(n0));
        check("fault_no_valid", {63'h0, if_valid}, 64'h0);
        do_redirect(64'h300);
        check("fault_clear", {63'h0, fetch_fault}, 64'h0);
        check("fault_resume_addr", imem_addr, 64'h300);
        exp_q.push_back('{64'h300, 32'hA000_0300});
        id_ready = 1'b1;
        wait_xfers(7);
        id_ready = 1'b0;
        check("fault_resume_log", acc_log[n0], 64'h300);

        // Wrapping PC and reset during an outstanding read.
        rst_w_n = 1'b1;
        wait_acc(1'b1, 2);
        check("wrap_addr0", log_w[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_addr1", log_w[1], 64'h0);
        check("wrap_out_pc", if_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_out_instr", {32'h0, if_instruction_w}, 64'hA000_FFFC);
        rst_w_n = 1'b0;
        #1;
        check("midrst_valid", {63'h0, if_valid_w}, 64'h0);
        check("midrst_nop", {32'h0, if_instruction_w}, {32'h0, NOP});
        check("midrst_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        rst_w_n = 1'b1;
        id_ready_w = 1'b1;
        for (int k = 0; k < 20 && !if_valid_w; k++) tick();
        check("restart_valid", {63'h0, if_valid_w}, 64'h1);
        check("restart_pc", if_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        check("restart_log", log_w[2], 64'hFFFF_FFFF_FFFF_FFFC);

        repeat (4) tick();
        check("scoreboard_drain", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
